// File: rtl/pixel_readout_driver.sv
// pixel_readout_driver: single-slope ADC for 2*N_SEL pixels plus pixel-databus transmitter.
// A conversion sweeps ramp_code from 0 to RAMP_MAX and latches each pixel's code on the first
// cycle its comparator reads high. Pixels that never fire store RAMP_MAX.
// The stored codes are then presented pairwise on pixData1/pixData2 under a one-hot read_select.
// Optional feature macro: PIX_BLACK_OFFSET_EN. It adds the black_level input and stores
// ramp_code - black_level, clamped at 0.
module pixel_readout_driver #(
    parameter int unsigned N_SEL    = 4,
    parameter int unsigned DATA_W   = 8,
    parameter int unsigned RAMP_MAX = 255
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 convert_start,
    input  logic [2*N_SEL-1:0]   cmp,
    input  logic                 read,
    input  logic [N_SEL-1:0]     read_select,
`ifdef PIX_BLACK_OFFSET_EN
    input  logic [DATA_W-1:0]    black_level,
`endif
    output logic [DATA_W-1:0]    pixData1,
    output logic [DATA_W-1:0]    pixData2,
    output logic [DATA_W-1:0]    ramp_code,
    output logic                 busy,
    output logic                 data_valid,
    output logic                 sel_error
);

    localparam int unsigned       NPix    = 2 * N_SEL;
    localparam logic [DATA_W-1:0] RampMax = DATA_W'(RAMP_MAX);

    typedef enum logic [1:0] {StIdle, StRamp, StReady} state_e;

    state_e              state_q, state_d;
    logic [DATA_W-1:0]   ramp_q, ramp_d;
    logic [DATA_W-1:0]   store_q [NPix];
    logic [DATA_W-1:0]   store_d [NPix];
    logic [NPix-1:0]     latched_q, latched_d;
    logic                sel_err_q, sel_err_d;
    logic [DATA_W-1:0]   code_val;
    logic                sel_onehot;
    logic                ramp_last;
    logic                restart;

`ifdef PIX_BLACK_OFFSET_EN
    logic [DATA_W-1:0]   black_q, black_d;
    assign code_val = (ramp_q >= black_q) ? (ramp_q - black_q) : '0;
`else
    assign code_val = ramp_q;
`endif

    assign sel_onehot = (read_select != '0) &&
                        ((read_select & (read_select - N_SEL'(1))) == '0);
    assign ramp_last  = (ramp_q == RampMax);
    // A start pulse is honoured everywhere except mid-ramp.
    assign restart    = convert_start && (state_q != StRamp);

    // Next-state: conversion sequencing, per-pixel latching and the illegal-read flag
    always_comb begin
        state_d   = state_q;
        ramp_d    = ramp_q;
        store_d   = store_q;
        latched_d = latched_q;
        sel_err_d = 1'b0;
`ifdef PIX_BLACK_OFFSET_EN
        black_d   = black_q;
`endif
        unique case (state_q)
            StIdle: begin
                state_d = StIdle;
            end
            StRamp: begin
                for (int i = 0; i < NPix; i++) begin
                    // On the final code every still-open pixel saturates.
                    if (!latched_q[i] && (cmp[i] || ramp_last)) begin
                        store_d[i]   = code_val;
                        latched_d[i] = 1'b1;
                    end
                end
                if (ramp_last) begin
                    state_d = StReady;
                    ramp_d  = '0;
                end else begin
                    ramp_d  = ramp_q + DATA_W'(1);
                end
            end
            StReady: begin
                sel_err_d = read && !sel_onehot;
                if (read && sel_onehot && read_select[N_SEL-1]) begin
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
        // Start overrides a simultaneous last-pair read.
        if (restart) begin
            state_d   = StRamp;
            ramp_d    = '0;
            latched_d = '0;
`ifdef PIX_BLACK_OFFSET_EN
            black_d   = black_level;
`endif
        end
    end

    // State register with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q   <= StIdle;
            ramp_q    <= '0;
            latched_q <= '0;
            sel_err_q <= 1'b0;
            for (int i = 0; i < NPix; i++) begin
                store_q[i] <= '0;
            end
`ifdef PIX_BLACK_OFFSET_EN
            black_q   <= '0;
`endif
        end else begin
            state_q   <= state_d;
            ramp_q    <= ramp_d;
            latched_q <= latched_d;
            sel_err_q <= sel_err_d;
            for (int i = 0; i < NPix; i++) begin
                store_q[i] <= store_d[i];
            end
`ifdef PIX_BLACK_OFFSET_EN
            black_q   <= black_d;
`endif
        end
    end

    // Zero-latency pair mux; only a one-hot select in READY drives data
    always_comb begin
        pixData1 = '0;
        pixData2 = '0;
        if (state_q == StReady && sel_onehot) begin
            for (int k = 0; k < N_SEL; k++) begin
                if (read_select[k]) begin
                    pixData1 = store_q[2*k];
                    pixData2 = store_q[2*k+1];
                end
            end
        end
    end

    assign ramp_code  = ramp_q;
    assign busy       = (state_q == StRamp);
    assign data_valid = (state_q == StReady);
    assign sel_error  = sel_err_q;

endmodule

// File: tb/tb_pixel_readout_driver.sv
// Self-checking bench for pixel_readout_driver: a cycle-level behavioural model is compared
// against every output each cycle. Directed scenarios pin the model with literal values, and a
// randomized phase follows.
module tb_pixel_readout_driver;

    localparam int NSel = 4;
    localparam int NPix = 8;
    localparam int RMax = 255;

    logic            clk = 1'b0;
    logic            reset;
    logic            convert_start;
    logic [NPix-1:0] cmp;
    logic            read;
    logic [NSel-1:0] read_select;
    logic [7:0]      black_level;
    logic [7:0]      pixData1, pixData2, ramp_code;
    logic            busy, data_valid, sel_error;

    pixel_readout_driver dut (
        .clk           (clk),
        .reset         (reset),
        .convert_start (convert_start),
        .cmp           (cmp),
        .read          (read),
        .read_select   (read_select),
`ifdef PIX_BLACK_OFFSET_EN
        .black_level   (black_level),
`endif
        .pixData1      (pixData1),
        .pixData2      (pixData2),
        .ramp_code     (ramp_code),
        .busy          (busy),
        .data_valid    (data_valid),
        .sel_error     (sel_error)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;
    int busy_seen = 0;

    // Behavioural model: phase 0 idle, 1 converting (m_cnt = cycles into the sweep), 2 data ready.
    int m_phase = 0;
    int m_cnt = 0;
    int m_black = 0;
    int m_code [NPix];
    bit m_lat [NPix];
    bit m_selerr = 0;

    int thr [NPix];

    task automatic chk(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic compare_all();
        int e1, e2;
        e1 = 0;
        e2 = 0;
        if (m_phase == 2 && $countones(read_select) == 1) begin
            for (int k = 0; k < NSel; k++) begin
                if (read_select[k]) begin
                    e1 = m_code[2*k];
                    e2 = m_code[2*k+1];
                end
            end
        end
        chk("busy", int'(busy), int'(m_phase == 1));
        chk("data_valid", int'(data_valid), int'(m_phase == 2));
        chk("ramp_code", int'(ramp_code), (m_phase == 1) ? m_cnt : 0);
        chk("sel_error", int'(sel_error), int'(m_selerr));
        chk("pixData1", int'(pixData1), e1);
        chk("pixData2", int'(pixData2), e2);
        if (busy) busy_seen++;
    endtask

    task automatic model_step();
        bit onehot;
        int c;
        onehot = ($countones(read_select) == 1);
        if (!reset) begin
            m_phase = 0;
            m_cnt = 0;
            m_black = 0;
            m_selerr = 0;
            for (int i = 0; i < NPix; i++) begin
                m_code[i] = 0;
                m_lat[i] = 0;
            end
            return;
        end
        m_selerr = (m_phase == 2) && read && !onehot;
        if (m_phase == 1) begin
            for (int i = 0; i < NPix; i++) begin
                if (!m_lat[i] && (cmp[i] || m_cnt == RMax)) begin
                    c = m_cnt - m_black;
                    m_code[i] = (c < 0) ? 0 : c;
                    m_lat[i] = 1;
                end
            end
            if (m_cnt == RMax) begin
                m_phase = 2;
                m_cnt = 0;
            end else begin
                m_cnt++;
            end
        end else if (convert_start) begin
            m_phase = 1;
            m_cnt = 0;
            for (int i = 0; i < NPix; i++) m_lat[i] = 0;
`ifdef PIX_BLACK_OFFSET_EN
            m_black = int'(black_level);
`else
            m_black = 0;
`endif
        end else if (m_phase == 2 && read && onehot && read_select[NSel-1]) begin
            m_phase = 0;
        end
    endtask

    task automatic tick();
        @(negedge clk);
        compare_all();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic start_conv();
        convert_start = 1'b1;
        tick();
        convert_start = 1'b0;
    endtask

    // Sweep the full ramp with cmp[i] rising at thr[i] (-1 = never); optional glitch on pixel 0.
    task automatic sweep(input bit glitch0);
        for (int j = 0; j <= RMax; j++) begin
            for (int i = 0; i < NPix; i++) cmp[i] = (thr[i] >= 0) && (j >= thr[i]);
            if (glitch0) cmp[0] = (j == 7) || (j >= 20);
            tick();
        end
        cmp = '0;
    endtask

    task automatic rd(input logic [NSel-1:0] sel, input int e1, input int e2, input string name);
        read = 1'b1;
        read_select = sel;
        #1;
        chk({name, "_p1"}, int'(pixData1), e1);
        chk({name, "_p2"}, int'(pixData2), e2);
        tick();
        read = 1'b0;
        read_select = '0;
    endtask

    initial begin
        reset = 1'b0;
        convert_start = 1'b0;
        cmp = '0;
        read = 1'b0;
        read_select = '0;
        black_level = '0;
        for (int i = 0; i < NPix; i++) begin
            m_code[i] = 0;
            m_lat[i] = 0;
        end
        @(posedge clk);
        #1;
        tick();
        tick();
        reset = 1'b1;
        tick();

        // Basic conversion: codes 10*i+5
        for (int i = 0; i < NPix; i++) thr[i] = 10 * i + 5;
        busy_seen = 0;
        start_conv();
        sweep(1'b0);
        chk("busy_cycles", busy_seen, 256);
        chk("ready_dv", int'(data_valid), 1);
        rd(4'b0001, 5, 15, "pair0");
        rd(4'b0010, 25, 35, "pair1");
        rd(4'b0100, 45, 55, "pair2");
        chk("dv_before_last", int'(data_valid), 1);
        rd(4'b1000, 65, 75, "pair3");
        chk("dv_after_last", int'(data_valid), 0);

        // Saturation and comparator glitch
        for (int i = 0; i < NPix; i++) thr[i] = 30 + i;
        thr[3] = -1;
        start_conv();
        sweep(1'b1);
        rd(4'b0001, 7, 31, "glitch");
        rd(4'b0010, 32, 255, "saturate");

        // Illegal selects keep READY and flag one cycle later
        rd(4'b0000, 0, 0, "sel_zero");
        chk("sel_err_zero", int'(sel_error), 1);
        chk("sel_err_zero_dv", int'(data_valid), 1);
        rd(4'b0110, 0, 0, "sel_multi");
        chk("sel_err_multi", int'(sel_error), 1);
        tick();
        chk("sel_err_clear", int'(sel_error), 0);

        // Restart in the same cycle as the last-pair read
        convert_start = 1'b1;
        rd(4'b1000, 36, 37, "restart_read");
        convert_start = 1'b0;
        chk("restart_busy", int'(busy), 1);
        chk("restart_ramp", int'(ramp_code), 0);
        for (int j = 0; j < 10; j++) tick();
        start_conv();
        chk("midramp_start", int'(ramp_code), 11);

        // Reset mid-ramp for two cycles
        reset = 1'b0;
        tick();
        tick();
        chk("rst_busy", int'(busy), 0);
        chk("rst_ramp", int'(ramp_code), 0);
        chk("rst_dv", int'(data_valid), 0);
        reset = 1'b1;
        tick();

`ifdef PIX_BLACK_OFFSET_EN
        for (int i = 0; i < NPix; i++) thr[i] = 100;
        thr[0] = 12;
        thr[1] = 50;
        thr[2] = -1;
        black_level = 8'd20;
        start_conv();
        black_level = 8'd0;
        sweep(1'b0);
        rd(4'b0001, 0, 30, "black0");
        rd(4'b0010, 235, 80, "black1");
`endif

        // Randomized traffic against the model
        for (int n = 0; n < 8000; n++) begin
            reset = ($urandom_range(0, 999) != 0);
            convert_start = ($urandom_range(0, 39) == 0);
            for (int i = 0; i < NPix; i++) cmp[i] = ($urandom_range(0, 59) == 0);
            read = $urandom_range(0, 1) == 1;
            if ($urandom_range(0, 9) < 7) read_select = NSel'(1) << $urandom_range(0, NSel - 1);
            else read_select = NSel'($urandom_range(0, 15));
            black_level = 8'($urandom_range(0, 63));
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/pixel_readout_driver.md
Name: pixel_readout_driver

Overview:
- Pixel-side transmitter for the pixel databus. It digitises 2*N_SEL pixel comparators with a single-slope ramp counter and stores one code per pixel.
- It then drives pixData1/pixData2 from the stored codes as the bus reader steps its one-hot read_select.
- It sits between the pixel array comparators/ramp DAC and the memory-side bus reader.

Parameters:
- N_SEL, 4, number of one-hot select lines; each select addresses one pixel pair.
- DATA_W, 8, code width and bus lane width.
- RAMP_MAX, 255, final ramp code; must be <= 2^DATA_W-1.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  synchronous, active-low reset.
- convert_start  input  1  single-cycle pulse that starts a conversion.
- cmp  input  2*N_SEL  per-pixel comparator outputs, synchronous to clk; 1 = ramp has passed the pixel level.
- read  input  1  bus read strobe from the reader.
- read_select  input  N_SEL  one-hot pair select from the reader.
- pixData1  output  DATA_W  code of pixel 2k for selected pair k.
- pixData2  output  DATA_W  code of pixel 2k+1 for selected pair k.
- ramp_code  output  DATA_W  current ramp DAC code.
- busy  output  1  high in RAMP.
- data_valid  output  1  high in READY.
- sel_error  output  1  registered single-cycle flag for an illegal read.

Behaviour:
- Reset (reset=0 at a clk edge):
  - state=IDLE; ramp_code=0; busy=0; data_valid=0; sel_error=0.
  - All stored codes=0; all latched flags=0.
  - pixData1=pixData2=0.
- States: IDLE, RAMP, READY.
- IDLE:
  - On convert_start=1 go to RAMP next cycle: ramp_code=0, all latched flags cleared.
  - read is ignored, pixData=0, no sel_error.
- RAMP:
  - busy=1. Each cycle, for each pixel i with latched[i]=0 and cmp[i]=1: store[i]<=ramp_code and latched[i]<=1.
  - A latched pixel never changes again, regardless of later cmp toggles.
  - ramp_code increments by 1 each cycle.
  - In the cycle where ramp_code==RAMP_MAX, evaluate cmp with that code first. Any pixel still unlatched then stores RAMP_MAX (saturated).
  - After that cycle go to READY. RAMP therefore lasts RAMP_MAX+1 cycles; ramp_code returns to 0.
  - convert_start is ignored in RAMP. read is ignored in RAMP, and sel_error stays 0.
- READY:
  - data_valid=1.
  - pixData1/pixData2 are combinational from read_select and the stored codes, with zero latency, so the reader can sample them in the same cycle as read.
  - read_select one-hot with bit k set: pixData1=store[2k], pixData2=store[2k+1].
  - read_select zero or multi-hot: pixData1=pixData2=0. If read=1 in that cycle, sel_error=1 in the next cycle.
  - A read with read_select[N_SEL-1]=1 is the last pair. The next state is IDLE and data_valid drops in the next cycle.
  - Reads may repeat a pair or skip pairs; no ordering is enforced.
  - convert_start in READY discards the stored data: go to RAMP, same as from IDLE.
  - If convert_start and the last-pair read occur in the same cycle, convert_start wins and the next state is RAMP. The read still sees the old data in that cycle.
- Outside READY, pixData1=pixData2=0.
- Arithmetic: ramp_code is DATA_W bits and never exceeds RAMP_MAX, so it does not wrap.
- Reset mid-RAMP or mid-READY aborts immediately to the reset state.

Optional Feature:
- Macro: PIX_BLACK_OFFSET_EN.
- With the macro defined:
  - Add input black_level[DATA_W-1:0], sampled on the convert_start cycle and held for the conversion.
  - Each stored value = ramp_code - black_level, clamped to 0 when ramp_code < black_level. This includes the saturated RAMP_MAX case.
- Without the macro: the port is absent and raw ramp codes are stored.

Test Plan:
- Reset check: reset=0 for 2 cycles mid-RAMP. Required: state IDLE, ramp_code=0, busy=0, data_valid=0, all outputs 0.
- Basic conversion: pulse convert_start; raise cmp[i] when ramp_code reaches 10*i+5 (i=0..7). Required: busy for exactly 256 cycles, then data_valid=1. Reads with read_select=0001, 0010, 0100, 1000 return pairs (5,15), (25,35), (45,55), (65,75). data_valid drops the cycle after the 1000 read.
- Saturation and glitch: cmp[3] never rises, and cmp[0] rises at code 7, falls at 8, rises again at 20. Required: store[3]=255 and store[0]=7.
- Illegal select: in READY, read=1 with read_select=0000, then 0110. Required: pixData1=pixData2=0 and sel_error=1 one cycle after each read. State stays READY.
- Restart: convert_start in READY in the same cycle as the read_select=1000 read. Required: that read returns the old data, then the block enters RAMP with ramp_code=0. convert_start in mid-RAMP does not restart the ramp.
- PIX_BLACK_OFFSET_EN: black_level=20; cmp[0] rises at code 12, cmp[1] at 50, cmp[2] never. Required: read_select=0001 gives pixData1=0, pixData2=30; read_select=0010 gives pixData1=235.
